sa_feeder: RTL and testbench

Input staging and skew stage directly upstream of the 3x3 systolic array (`sysa`). It buffers one N×N activation matrix written row by row and streams it into the array as diagonally skewed lane vectors, one beat per `step` strobe. It then appends N-1 zero drain beats so the array's last partial sums propagate out. It drives the array's `in` and `en` inputs, replacing ad-hoc bus-to-array writes.

---
 rtl/edu_tpu_pkg.sv | 17 +
 rtl/sa_feeder.sv | 126 ++++++++++++
 tb/tb_sa_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edu_tpu_pkg.sv
// Shared constants for the teaching TPU datapath: array geometry,
// element widths and the feeder's control-state encoding.
package edu_tpu_pkg;

    localparam int ARRAY_SIZE = 3;
    localparam int DATA_W     = 8;
    localparam int ACC_W      = 2 * DATA_W + $clog2(ARRAY_SIZE) + 1;

    // Beats per streamed matrix: 2N-1 skewed data beats plus N-1 drain beats.
    localparam int BEAT_COUNT = 3 * ARRAY_SIZE - 2;

    // Feeder control states.
    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

endpackage

// File: rtl/sa_feeder.sv
// Activation staging buffer and diagonal skew stage in front of the
// systolic array. Rows are loaded one per write, then streamed out one
// skewed lane vector per step strobe, followed by zero drain beats.
module sa_feeder #(
    parameter int ARRAY_SIZE = edu_tpu_pkg::ARRAY_SIZE,
    parameter int DATA_W     = edu_tpu_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ARRAY_SIZE*DATA_W-1:0] wr_data,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         step,
    output logic                         busy,
    output logic                         out_valid,
    output logic [ARRAY_SIZE*DATA_W-1:0] out_data,
    output logic                         done
);
    import edu_tpu_pkg::ST_FILL;
    import edu_tpu_pkg::ST_READY;
    import edu_tpu_pkg::ST_STREAM;

    localparam int BEATS  = 3 * ARRAY_SIZE - 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W  = $clog2(ARRAY_SIZE + 1);
    localparam int SEL_W  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ARRAY_SIZE - 1);

    logic [1:0]                   state;
    logic [ROW_W-1:0]             row_cnt;
    logic [BEAT_W-1:0]            beat;
    logic [ARRAY_SIZE*DATA_W-1:0] rows [ARRAY_SIZE];
    logic [ARRAY_SIZE*DATA_W-1:0] skew_data;

    // Handshake and status are pure decodes of the registered state.
    assign wr_ready = (state == ST_FILL);
    assign busy     = (state == ST_STREAM);

    // Capture accepted rows into the row buffer.
    // NOTE: the row buffer has no reset; every row is rewritten during FILL
    // before STREAM can read it, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (!clear && state == ST_FILL && wr_valid) begin
            rows[row_cnt[SEL_W-1:0]] <= wr_data;
        end
    end

    // Per-lane skew select: lane k on beat t carries A[t-k][k] when that row exists.
    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
        logic [BEAT_W-1:0] diff;
        logic              hit;
        logic [SEL_W-1:0]  row_sel;
        logic [DATA_W-1:0] lane;

        // Row index for this lane on the current beat, and whether it is in range.
        always_comb begin
            diff    = beat - BEAT_W'(k);
            hit     = (beat >= BEAT_W'(k)) && (diff < BEAT_W'(ARRAY_SIZE));
            row_sel = diff[SEL_W-1:0];
            lane    = hit ? rows[row_sel][k*DATA_W +: DATA_W] : '0;
        end

        assign skew_data[k*DATA_W +: DATA_W] = lane;
    end

    // Control FSM, counters and registered stream outputs; clear overrides all.
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            row_cnt   <= '0;
            beat      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (clear) begin
                state    <= ST_FILL;
                row_cnt  <= '0;
                beat     <= '0;
                out_data <= '0;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (wr_valid) begin
                            row_cnt <= row_cnt + 1'b1;
                            if (row_cnt == LAST_ROW) begin
                                state <= ST_READY;
                            end
                        end
                    end
                    ST_READY: begin
                        if (start) begin
                            state <= ST_STREAM;
                            beat  <= '0;
                        end
                    end
                    ST_STREAM: begin
                        // The final beat is on the outputs this cycle; return to FILL.
                        if (done) begin
                            state   <= ST_FILL;
                            row_cnt <= '0;
                            beat    <= '0;
                        end else if (step) begin
                            out_valid <= 1'b1;
                            out_data  <= skew_data;
                            done      <= (beat == LAST_BEAT);
                            beat      <= (beat == LAST_BEAT) ? beat : beat + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_FILL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: directed and random matrices streamed
// at several step rates, checked against a matrix-level skew model.
module tb_sa_feeder;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int BEATS = 3 * N - 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [N*DW-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic            step = 1'b0;
    logic            busy;
    logic            out_valid;
    logic [N*DW-1:0] out_data;
    logic            done;

    int n_vec = 0;
    int n_bad = 0;
    int mat [N][N];

    sa_feeder #(.ARRAY_SIZE(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .start     (start),
        .clear     (clear),
        .step      (step),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat t of the skewed stream: lane k carries A[t-k][k] if that row exists.
    function automatic logic [N*DW-1:0] model_beat(input int t);
        logic [N*DW-1:0] v = '0;
        for (int k = 0; k < N; k++) begin
            int r = t - k;
            if (r >= 0 && r < N) v[k*DW +: DW] = DW'(mat[r][k]);
        end
        return v;
    endfunction

    function automatic logic [N*DW-1:0] row_word(input int r);
        logic [N*DW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(mat[r][k]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                mat[r][k] = int'($urandom_range(1, 255));
    endtask

    task automatic write_row(input int r);
        wr_valid = 1'b1;
        wr_data  = row_word(r);
        check("wr_ready_fill", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load_matrix();
        for (int r = 0; r < N; r++) write_row(r);
        check("wr_ready_loaded", wr_ready, 0);
    endtask

    task automatic start_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Drive steps (period 0 = random) and check every cycle until done.
    task automatic stream_check(input int period);
        int              t = 0;
        int              cyc = 0;
        int              pulses = 0;
        bit              s;
        bit              fin = 1'b0;
        logic [N*DW-1:0] exp_data = '0;
        while (!fin && cyc < BEATS * 8 + 20) begin
            if (period == 0) s = ($urandom_range(0, 2) != 0);
            else             s = ((cyc % period) == 0);
            step = s;
            tick();
            cyc++;
            if (s) exp_data = model_beat(t);
            check("out_valid", out_valid, 32'(s));
            check("out_data", out_data, 32'(exp_data));
            check("done", done, 32'(s && t == BEATS - 1));
            if (out_valid) pulses++;
            if (s) begin
                if (t == BEATS - 1) fin = 1'b1;
                t++;
            end
        end
        step = 1'b0;
        check("stream_completed", 32'(fin), 1);
        check("pulse_count", pulses, BEATS);
        tick();
        check("wr_ready_after_done", wr_ready, 1);
        check("busy_after_done", busy, 0);
        check("valid_after_done", out_valid, 0);
        check("data_held_after_done", out_data, 32'(exp_data));
    endtask

    initial begin
        // Reset values while rst_n is low.
        #3;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed matrix, full-rate streaming.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                mat[r][k] = N * r + k + 1;
        load_matrix();
        start_stream();
        stream_check(1);

        // Same matrix, one step every 4th cycle.
        load_matrix();
        start_stream();
        stream_check(4);

        // Two rows then start is ignored; a write in READY is refused.
        fill_random();
        write_row(0);
        write_row(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("partial_no_busy", busy, 0);
        check("partial_wr_ready", wr_ready, 1);
        write_row(2);
        check("ready_wr_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 24'hA5A5A5;
        tick();
        wr_valid = 1'b0;
        check("ready_still_idle", busy, 0);
        start_stream();
        stream_check(1);

        // Clear with the 4th step: no 4th beat, no done.
        fill_random();
        load_matrix();
        start_stream();
        for (int t = 0; t < 3; t++) begin
            step = 1'b1;
            tick();
            check("pre_clear_data", out_data, 32'(model_beat(t)));
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        step  = 1'b0;
        check("clear_valid", out_valid, 0);
        check("clear_done", done, 0);
        check("clear_busy", busy, 0);
        check("clear_data", out_data, 0);
        check("clear_wr_ready", wr_ready, 1);

        // Asynchronous reset mid-stream, then a fresh load.
        fill_random();
        load_matrix();
        start_stream();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_wr_ready", wr_ready, 1);
        check("async_busy", busy, 0);
        check("async_valid", out_valid, 0);
        check("async_done", done, 0);
        check("async_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        load_matrix();
        start_stream();
        stream_check(1);

        // step held high through FILL and READY, and in the start cycle.
        fill_random();
        step = 1'b1;
        load_matrix();
        check("held_step_fill_valid", out_valid, 0);
        tick();
        check("held_step_ready_valid", out_valid, 0);
        start_stream();
        check("held_step_start_valid", out_valid, 0);
        stream_check(1);

        // Random matrices with random step gaps.
        for (int i = 0; i < 4; i++) begin
            fill_random();
            load_matrix();
            start_stream();
            stream_check(i == 3 ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
